led_ctrl_top: RTL and testbench
===============================

LED_CTRL_TOP -- requirements
Module: led_ctrl_top

Interface
REQ-001 The block SHALL have one clock, clk_fast (input, 1, rising-edge), with all state synchronous to it.
REQ-002 The block SHALL have reset rstn (input, 1), asynchronous and active-low.
REQ-003 en  input  1  single-cycle pulse; toggles internal output-enable flag oe.
REQ-004 start  input  1  single-cycle pulse; requests one frame.
REQ-005 MeanR, MeanG, MeanB  input  16 x 4 unpacked arrays [15:0]  per-pixel colour levels, pixel i = index i.
REQ-006 cko_o  output  1  shift clock to LED drivers; receivers sample sdo on its rising edge.
REQ-007 sdo  output  8  parallel data byte.
REQ-008 busy  output  1  high from frame accept to frame end.
REQ-009 done  output  1  one-cycle pulse at frame end.

Function
REQ-010 The block SHALL implement states IDLE -> FILL -> LOAD <-> SHIFT -> IDLE.
REQ-011 IDLE: start=1 -> FILL next cycle, busy=1; start while busy SHALL be ignored.
REQ-012 FILL: 16 cycles; cycle i (0..15) writes word {MeanR[i],MeanG[i],MeanB[i]} (R in [11:8]) into an internal 16x12 FIFO; inputs are sampled during FILL, not at start.
REQ-013 The FIFO SHALL be show-ahead (read data = head word combinationally, pop on rd), with 4-bit wrapping pointers and a 5-bit count; empty = count 0, full = count 16.
REQ-014 LOAD: 2 cycles, popping word A then word B, forming 24-bit pair P = {A,B}.
REQ-015 SHIFT: 3 bytes P[23:16], P[15:8], P[7:0], 2 cycles each: phase 0 drives sdo = byte and cko_o = 0; phase 1 holds sdo and sets cko_o = 1.
REQ-016 After the third byte: return to LOAD if the FIFO is not empty; otherwise go to IDLE.
REQ-017 A frame SHALL be 8 pairs and 24 bytes: 16 FILL + 8 x (2 LOAD + 6 SHIFT) = 80 cycles from the first FILL cycle to the last SHIFT cycle.
REQ-018 On the cycle after the last SHIFT phase: done = 1 for one cycle, busy = 0, cko_o = 0, sdo = 0x00, state = IDLE.
REQ-019 Outside SHIFT, cko_o = 0 and sdo = 0x00.
REQ-020 oe (reset 1) SHALL toggle on every en pulse, in any state.
REQ-021 While oe = 0, cko_o and sdo SHALL be forced to 0, while internal sequencing, busy and done continue unchanged.
REQ-022 start and en in the same cycle SHALL both take effect.
REQ-023 A FIFO write when full or a pop when empty SHALL be ignored and cannot occur in normal sequencing.

Reset
REQ-024 rstn = 0 SHALL immediately set: state IDLE, FIFO pointers/count 0, oe = 1, busy = 0, done = 0, cko_o = 0, sdo = 0x00.
REQ-025 Reset mid-frame SHALL abort the frame with no done pulse; the next start after release begins a fresh frame.

Configuration
REQ-026 With macro LED_CTRL_BGR_EN defined, FIFO words SHALL be packed {MeanB[i],MeanG[i],MeanR[i]}; without it, packing is {R,G,B} per REQ-012.

Verification
REQ-027 Reset, then start with R[0]=1,G[0]=F,B[0]=7,R[1]=2,G[1]=E,B[1]=4 -> first three bytes sampled on cko_o rising are 0x1F, 0x72, 0xE4 (BGR build: 0x7F, 0x14, 0xE2).
REQ-028 Single start -> exactly 24 cko_o rising edges; done pulses once, 81 cycles after the start cycle; busy high throughout.
REQ-029 Second start pulse mid-frame -> ignored; still 24 edges, one done.
REQ-030 en pulse before start -> sdo = 0 and cko_o = 0 for the whole frame, done still pulses. Second en pulse -> output restored on the next frame.
REQ-031 rstn low during SHIFT of byte 10 -> outputs 0 immediately, no done. A new start after release -> a full 24-byte frame starting with byte 0.
REQ-032 Back-to-back start 1 cycle after done -> second frame identical; FIFO empty between frames.

Source files
------------

// File: rtl/led_ctrl_top.sv
// LED driver frame sequencer: FILL a 16x12 show-ahead FIFO, then shift pixel pairs out as bytes.
// Define LED_CTRL_BGR_EN to pack FIFO words as {B,G,R} instead of the default {R,G,B}.
module led_ctrl_top (
    input  logic       clk_fast,
    input  logic       rstn,
    input  logic       en,
    input  logic       start,
    input  logic [3:0] MeanR [15:0],
    input  logic [3:0] MeanG [15:0],
    input  logic [3:0] MeanB [15:0],
    output logic       cko_o,
    output logic [7:0] sdo,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, FILL, LOAD, SHIFT} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  step_reg, step_next;
    logic        done_reg, done_next;
    logic        oe_reg;
    logic [23:0] pair_reg;

    logic [11:0] fifo_mem [16];
    logic [3:0]  wr_ptr_reg, rd_ptr_reg;
    logic [4:0]  count_reg;
    logic        fifo_wr, fifo_rd, wr_ok, rd_ok, fifo_empty, fifo_full;
    logic [11:0] fifo_rd_data, fifo_wr_data;

    logic [11:0] pix_word [16];
    logic [7:0]  byte_sel;

    for (genvar gi = 0; gi < 16; gi++) begin : g_pack
`ifdef LED_CTRL_BGR_EN
        assign pix_word[gi] = {MeanB[gi], MeanG[gi], MeanR[gi]};
`else
        assign pix_word[gi] = {MeanR[gi], MeanG[gi], MeanB[gi]};
`endif
    end

    assign fifo_empty   = (count_reg == 5'd0);
    assign fifo_full    = (count_reg == 5'd16);
    assign wr_ok        = fifo_wr && !fifo_full;
    assign rd_ok        = fifo_rd && !fifo_empty;
    assign fifo_rd_data = fifo_mem[rd_ptr_reg];
    assign fifo_wr_data = pix_word[step_reg];

    // Storage has no reset; validity is tracked solely by count_reg.
    always_ff @(posedge clk_fast) begin
        if (wr_ok) begin
            fifo_mem[wr_ptr_reg] <= fifo_wr_data;
        end
    end

    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= 4'd0;
            rd_ptr_reg <= 4'd0;
            count_reg  <= 5'd0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 4'd1;
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 4'd1;
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            step_reg  <= 4'd0;
            done_reg  <= 1'b0;
            oe_reg    <= 1'b1;
            pair_reg  <= 24'd0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            done_reg  <= done_next;
            if (en) oe_reg <= ~oe_reg;
            if (state_reg == LOAD) begin
                if (step_reg[0]) pair_reg[11:0]  <= fifo_rd_data;
                else             pair_reg[23:12] <= fifo_rd_data;
            end
        end
    end

    // step_reg counts FILL words (0..15), LOAD pops (0..1) and SHIFT half-bytes (0..5).
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        done_next  = 1'b0;
        fifo_wr    = 1'b0;
        fifo_rd    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FILL;
                    step_next  = 4'd0;
                end
            end
            FILL: begin
                fifo_wr   = 1'b1;
                step_next = step_reg + 4'd1;
                if (step_reg == 4'd15) begin
                    state_next = LOAD;
                    step_next  = 4'd0;
                end
            end
            LOAD: begin
                fifo_rd   = 1'b1;
                step_next = step_reg + 4'd1;
                if (step_reg == 4'd1) begin
                    state_next = SHIFT;
                    step_next  = 4'd0;
                end
            end
            SHIFT: begin
                step_next = step_reg + 4'd1;
                if (step_reg == 4'd5) begin
                    step_next = 4'd0;
                    if (!fifo_empty) begin
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                step_next  = 4'd0;
            end
        endcase
    end

    always_comb begin
        case (step_reg[2:1])
            2'd0:    byte_sel = pair_reg[23:16];
            2'd1:    byte_sel = pair_reg[15:8];
            default: byte_sel = pair_reg[7:0];
        endcase
    end

    assign sdo   = (state_reg == SHIFT && oe_reg) ? byte_sel : 8'h00;
    assign cko_o = (state_reg == SHIFT) && oe_reg && step_reg[0];
    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;

endmodule

// File: tb/tb_led_ctrl_top.sv
// Directed bench for led_ctrl_top: frame timing, byte stream, oe gating, restart and reset abort.
module tb_led_ctrl_top;

    logic       clk_fast;
    logic       rstn;
    logic       en;
    logic       start;
    logic [3:0] MeanR [15:0];
    logic [3:0] MeanG [15:0];
    logic [3:0] MeanB [15:0];
    logic       cko_o;
    logic [7:0] sdo;
    logic       busy;
    logic       done;

    led_ctrl_top dut (
        .clk_fast (clk_fast),
        .rstn     (rstn),
        .en       (en),
        .start    (start),
        .MeanR    (MeanR),
        .MeanG    (MeanG),
        .MeanB    (MeanB),
        .cko_o    (cko_o),
        .sdo      (sdo),
        .busy     (busy),
        .done     (done)
    );

    initial clk_fast = 1'b0;
    always #5 clk_fast = ~clk_fast;

    int         checks = 0;
    int         errors = 0;
    int         edges, dones, done_at, busy_bad, nz_out;
    logic       done_busy, cko_prev;
    logic [7:0] got_bytes [$];
    logic [7:0] exp_bytes [24];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int i);
`ifdef LED_CTRL_BGR_EN
        return {MeanB[i], MeanG[i], MeanR[i]};
`else
        return {MeanR[i], MeanG[i], MeanB[i]};
`endif
    endfunction

    function automatic int byte_mismatches();
        int n = 0;
        for (int i = 0; i < got_bytes.size() && i < 24; i++)
            if (got_bytes[i] !== exp_bytes[i]) n++;
        return n;
    endfunction

    // Pulses start (optionally with en) and watches the frame until one cycle past done.
    task automatic run_frame(input int mid_start_at, input logic en_with_start);
        edges = 0; dones = 0; done_at = -1; busy_bad = 0; nz_out = 0;
        done_busy = 1'bx; cko_prev = 1'b0;
        got_bytes.delete();
        start = 1'b1;
        en    = en_with_start;
        for (int t = 1; t <= 140; t++) begin
            @(posedge clk_fast); #1;
            start = (t == mid_start_at);
            en    = 1'b0;
            if (cko_o && !cko_prev) begin
                edges++;
                got_bytes.push_back(sdo);
            end
            cko_prev = cko_o;
            if (cko_o || sdo != 8'h00) nz_out++;
            if (done) begin
                dones++;
                if (done_at < 0) begin
                    done_at   = t;
                    done_busy = busy;
                end
            end else if (done_at < 0 && !busy) begin
                busy_bad++;
            end
            if (done_at >= 0 && t >= done_at + 1) break;
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin @(posedge clk_fast); #1; end
    endtask

    initial begin
        logic [23:0] p;
        logic [7:0]  e0, e1, e2;
`ifdef LED_CTRL_BGR_EN
        e0 = 8'h7F; e1 = 8'h14; e2 = 8'hE2;
`else
        e0 = 8'h1F; e1 = 8'h72; e2 = 8'hE4;
`endif
        for (int i = 0; i < 16; i++) begin
            MeanR[i] = 4'(i);
            MeanG[i] = 4'(15 - i);
            MeanB[i] = 4'(i * 3);
        end
        MeanR[0] = 4'h1; MeanG[0] = 4'hF; MeanB[0] = 4'h7;
        MeanR[1] = 4'h2; MeanG[1] = 4'hE; MeanB[1] = 4'h4;
        for (int k = 0; k < 8; k++) begin
            p = {pix(2 * k), pix(2 * k + 1)};
            exp_bytes[3 * k]     = p[23:16];
            exp_bytes[3 * k + 1] = p[15:8];
            exp_bytes[3 * k + 2] = p[7:0];
        end

        rstn = 1'b0; en = 1'b0; start = 1'b0;
        tick_n(2);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cko", cko_o, 1'b0);
        check("rst_sdo", sdo, 8'h00);
        rstn = 1'b1;
        tick_n(2);

        run_frame(0, 1'b0);
        check("f1_edges", edges, 24);
        check("f1_dones", dones, 1);
        check("f1_done_at", done_at, 81);
        check("f1_busy_gap", busy_bad, 0);
        check("f1_busy_at_done", done_busy, 1'b0);
        check("f1_byte0", got_bytes.size() > 0 ? got_bytes[0] : 8'hxx, e0);
        check("f1_byte1", got_bytes.size() > 1 ? got_bytes[1] : 8'hxx, e1);
        check("f1_byte2", got_bytes.size() > 2 ? got_bytes[2] : 8'hxx, e2);
        check("f1_stream", byte_mismatches(), 0);
        check("idle_cko", cko_o, 1'b0);
        check("idle_sdo", sdo, 8'h00);

        run_frame(0, 1'b0);
        check("b2b_edges", edges, 24);
        check("b2b_dones", dones, 1);
        check("b2b_done_at", done_at, 81);
        check("b2b_stream", byte_mismatches(), 0);
        tick_n(3);

        run_frame(30, 1'b0);
        check("mid_edges", edges, 24);
        check("mid_dones", dones, 1);
        check("mid_done_at", done_at, 81);
        check("mid_stream", byte_mismatches(), 0);
        tick_n(3);

        en = 1'b1; tick_n(1); en = 1'b0;
        tick_n(2);
        run_frame(0, 1'b0);
        check("oe_off_edges", edges, 0);
        check("oe_off_nonzero", nz_out, 0);
        check("oe_off_dones", dones, 1);
        check("oe_off_done_at", done_at, 81);
        tick_n(3);

        run_frame(0, 1'b1);
        check("oe_on_edges", edges, 24);
        check("oe_on_dones", dones, 1);
        check("oe_on_stream", byte_mismatches(), 0);
        tick_n(3);

        edges = 0; cko_prev = 1'b0;
        start = 1'b1;
        for (int t = 1; t <= 140; t++) begin
            @(posedge clk_fast); #1;
            start = 1'b0;
            if (cko_o && !cko_prev) edges++;
            cko_prev = cko_o;
            if (edges == 11) break;
        end
        check("abort_edge", edges, 11);
        check("abort_cko_pre", cko_o, 1'b1);
        rstn = 1'b0;
        #1;
        check("abort_cko", cko_o, 1'b0);
        check("abort_sdo", sdo, 8'h00);
        check("abort_busy", busy, 1'b0);
        dones = 0;
        tick_n(1);
        rstn = 1'b1;
        for (int t = 0; t < 90; t++) begin
            tick_n(1);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_idle_busy", busy, 1'b0);

        run_frame(0, 1'b0);
        check("post_edges", edges, 24);
        check("post_dones", dones, 1);
        check("post_byte0", got_bytes.size() > 0 ? got_bytes[0] : 8'hxx, e0);
        check("post_stream", byte_mismatches(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
